mem_io_stage: RTL and testbench

//  Memory/IO access stage placed directly downstream of the execute unit in the

---
 rtl/mem_io_stage.sv | 128 ++++++++++++
 tb/tb_mem_io_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_io_stage.sv
// Memory/IO access stage: word loads/stores to data RAM (multi-cycle read) or
// memory-mapped LED/switch IO. Loads to RAM stall fetch until data is captured.
module mem_io_stage #(
  parameter int          MEM_ADDR_W   = 14,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] IO_BASE      = 32'hFFFF_FC00,
  parameter logic [9:0]  LED_OFF      = 10'h060,
  parameter logic [9:0]  SW_OFF       = 10'h070
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           ALU_Result,
  input  logic [31:0]           Write_data,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [15:0]           switch_in,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [31:0]           r_wdata,
  output logic                  stall,
  output logic [15:0]           led_out
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic       is_io;
    logic [9:0] io_off;
    logic       st;
    logic       ld;
  } req_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [31:0] rdata_q, io_rdata;
  logic [15:0] sw_sync1, sw_sync2;
  logic        led_we, cap;
  req_t        req;

  // A simultaneous read+write is a store; the read side is dropped here.
  assign req.is_io  = (ALU_Result >= IO_BASE);
  assign req.io_off = ALU_Result[9:0];
  assign req.st     = MemWrite;
  assign req.ld     = MemRead & ~MemWrite;

  assign mem_addr  = ALU_Result[MEM_ADDR_W+1:2];
  assign mem_wdata = Write_data;

  always_comb begin
    io_rdata = 32'h0;
    if (req.io_off == SW_OFF)       io_rdata = {16'h0, sw_sync2};
    else if (req.io_off == LED_OFF) io_rdata = {16'h0, led_out};
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    stall     = 1'b0;
    r_wdata   = ALU_Result;
    led_we    = 1'b0;
    cap       = 1'b0;
    case (state)
      IDLE: begin
        if (req.st) begin
          if (!req.is_io) begin
            mem_en = 1'b1;
            mem_we = 1'b1;
          end else if (req.io_off == LED_OFF) begin
            led_we = 1'b1;
          end
        end else if (req.ld) begin
          if (req.is_io) begin
            r_wdata = io_rdata;
          end else begin
            mem_en    = 1'b1;
            stall     = 1'b1;
            cnt_nxt   = LAT;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall   = 1'b1;
        mem_en  = 1'b1;
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) begin
          cap       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        r_wdata   = rdata_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset must not let a half-decoded access reach the RAM or hold fetch.
    if (reset) begin
      mem_en = 1'b0;
      mem_we = 1'b0;
      stall  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      rdata_q  <= 32'h0;
      led_out  <= 16'h0;
      sw_sync1 <= 16'h0;
      sw_sync2 <= 16'h0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sw_sync1 <= switch_in;
      sw_sync2 <= sw_sync1;
      if (cap)    rdata_q <= mem_rdata;
      if (led_we) led_out <= Write_data[15:0];
    end
  end
endmodule

// File: tb/tb_mem_io_stage.sv
// Directed bench for mem_io_stage; four instances at READ_LATENCY 1..4 share
// stimulus, each with its own latency-accurate RAM read pipe.
module tb_mem_io_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ALU_Result, Write_data;
  logic        MemRead, MemWrite;
  logic [15:0] switch_in;

  logic [31:0] rd   [4];
  logic [3:0]  men, mwe, stl;
  logic [13:0] maddr[4];
  logic [31:0] mwd  [4];
  logic [31:0] rw   [4];
  logic [15:0] led  [4];

  logic [31:0] ram [256];
  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  always @(posedge clock) if (mwe[0]) ram[maddr[0][7:0]] <= mwd[0];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [31:0] pd [4];
    logic [3:0]  pv;
    mem_io_stage #(.READ_LATENCY(g + 1)) u_dut (
      .clock(clock), .reset(reset), .ALU_Result(ALU_Result), .Write_data(Write_data),
      .MemRead(MemRead), .MemWrite(MemWrite), .switch_in(switch_in), .mem_rdata(rd[g]),
      .mem_en(men[g]), .mem_we(mwe[g]), .mem_addr(maddr[g]), .mem_wdata(mwd[g]),
      .r_wdata(rw[g]), .stall(stl[g]), .led_out(led[g]));
    // Read data is only valid g+1 cycles after the enable; garbage otherwise.
    always @(posedge clock) begin
      pd[0] <= ram[maddr[g][7:0]];
      pv[0] <= men[g] & ~mwe[g];
      for (int i = 1; i < 4; i++) begin
        pd[i] <= pd[i-1];
        pv[i] <= pv[i-1];
      end
    end
    assign rd[g] = pv[g] ? pd[g] : 32'hBAD0_BAD0;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    MemRead = 0; MemWrite = 0; ALU_Result = 32'h0; Write_data = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1; idle_in(); switch_in = 16'h0;
    step(); step();
    MemRead = 1; ALU_Result = 32'h10;
    @(negedge clock);
    total++; if (stl[0] !== 1'b0) $display("FAIL rst_stall got %b exp 0", stl[0]); else passed++;
    total++; if (men[0] !== 1'b0) $display("FAIL rst_mem_en got %b exp 0", men[0]); else passed++;
    total++; if (led[0] !== 16'h0) $display("FAIL rst_led got %h exp 0000", led[0]); else passed++;
    step();
    reset = 0; idle_in(); ALU_Result = 32'h1234;
    @(negedge clock);
    total++; if (stl !== 4'h0) $display("FAIL rst_idle_stall got %b exp 0000", stl); else passed++;
    total++; if (rw[0] !== 32'h1234) $display("FAIL rst_idle_rw got %h exp 00001234", rw[0]); else passed++;
    step();
  endtask

  task automatic test_ram();
    ALU_Result = 32'h10; Write_data = 32'hDEADBEEF; MemWrite = 1;
    @(negedge clock);
    total++; if (mwe[0] !== 1'b1 || men[0] !== 1'b1) $display("FAIL st_we got en=%b we=%b exp 1 1", men[0], mwe[0]); else passed++;
    total++; if (maddr[0] !== 14'd4) $display("FAIL st_addr got %0d exp 4", maddr[0]); else passed++;
    total++; if (mwd[0] !== 32'hDEADBEEF || stl[0] !== 1'b0) $display("FAIL st_data got %h stall=%b exp deadbeef 0", mwd[0], stl[0]); else passed++;
    step();
    MemWrite = 0; MemRead = 1; Write_data = 32'h0;
    @(negedge clock);
    total++; if (stl[0] !== 1'b1 || men[0] !== 1'b1 || mwe[0] !== 1'b0) $display("FAIL ld_c0 got st=%b en=%b we=%b exp 1 1 0", stl[0], men[0], mwe[0]); else passed++;
    step();
    @(negedge clock);
    total++; if (stl[0] !== 1'b1 || mwe[0] !== 1'b0 || maddr[0] !== 14'd4) $display("FAIL ld_wait got st=%b we=%b a=%0d exp 1 0 4", stl[0], mwe[0], maddr[0]); else passed++;
    step();
    @(negedge clock);
    total++; if (stl[0] !== 1'b0 || men[0] !== 1'b0) $display("FAIL ld_done_st got st=%b en=%b exp 0 0", stl[0], men[0]); else passed++;
    total++; if (rw[0] !== 32'hDEADBEEF) $display("FAIL ld_done_rw got %h exp deadbeef", rw[0]); else passed++;
    step();
    idle_in();
    repeat (6) step();
  endtask

  task automatic test_latency();
    int       sc [4];
    bit       dn [4];
    logic [31:0] got [4];
    ALU_Result = 32'h40; Write_data = 32'h0BAD_F00D; MemWrite = 1;
    step();
    MemWrite = 0; Write_data = 32'h0; MemRead = 1;
    for (int g = 0; g < 4; g++) begin sc[g] = 0; dn[g] = 0; got[g] = 32'h0; end
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      for (int g = 0; g < 4; g++) begin
        if (!dn[g]) begin
          if (stl[g]) sc[g]++;
          else if (sc[g] > 0) begin got[g] = rw[g]; dn[g] = 1; end
        end
      end
      step();
    end
    for (int g = 0; g < 4; g++) begin
      total++; if (sc[g] !== g + 2) $display("FAIL lat%0d_stall got %0d exp %0d", g + 1, sc[g], g + 2); else passed++;
      total++; if (got[g] !== 32'h0BAD_F00D) $display("FAIL lat%0d_data got %h exp 0badf00d", g + 1, got[g]); else passed++;
    end
    idle_in(); reset = 1;
    step();
    reset = 0;
    step();
  endtask

  task automatic test_io();
    ALU_Result = 32'hFFFF_FC60; Write_data = 32'h0000_A5A5; MemWrite = 1;
    @(negedge clock);
    total++; if (men[0] !== 1'b0 || stl[0] !== 1'b0) $display("FAIL io_st got en=%b st=%b exp 0 0", men[0], stl[0]); else passed++;
    step();
    idle_in(); switch_in = 16'h1234;
    @(negedge clock);
    total++; if (led[0] !== 16'hA5A5) $display("FAIL io_led got %h exp a5a5", led[0]); else passed++;
    step(); step();
    ALU_Result = 32'hFFFF_FC70; MemRead = 1;
    @(negedge clock);
    total++; if (rw[0] !== 32'h0000_1234 || stl[0] !== 1'b0) $display("FAIL io_sw got %h st=%b exp 00001234 0", rw[0], stl[0]); else passed++;
    step();
    ALU_Result = 32'hFFFF_FC60;
    @(negedge clock);
    total++; if (rw[0] !== 32'h0000_A5A5) $display("FAIL io_ledrd got %h exp 0000a5a5", rw[0]); else passed++;
    step();
    idle_in();
  endtask

  task automatic test_unmapped();
    ALU_Result = 32'hFFFF_FC80; MemRead = 1;
    @(negedge clock);
    total++; if (rw[0] !== 32'h0 || stl[0] !== 1'b0) $display("FAIL um_ld got %h st=%b exp 0 0", rw[0], stl[0]); else passed++;
    step();
    MemRead = 0; MemWrite = 1; Write_data = 32'h0000_1111;
    @(negedge clock);
    total++; if (men[0] !== 1'b0) $display("FAIL um_st_en got %b exp 0", men[0]); else passed++;
    step();
    idle_in(); ALU_Result = 32'h55;
    @(negedge clock);
    total++; if (led[0] !== 16'hA5A5) $display("FAIL um_led got %h exp a5a5", led[0]); else passed++;
    total++; if (rw[0] !== 32'h55) $display("FAIL nop_rw got %h exp 00000055", rw[0]); else passed++;
    step();
  endtask

  task automatic test_reset_wait();
    idle_in(); ALU_Result = 32'h10; MemRead = 1;
    step();
    step();
    @(negedge clock);
    total++; if (stl[2] !== 1'b1) $display("FAIL rw_pre got %b exp 1", stl[2]); else passed++;
    reset = 1;
    @(negedge clock);
    #1;
    total++; if (stl[2] !== 1'b0 || men[2] !== 1'b0) $display("FAIL rw_inrst got st=%b en=%b exp 0 0", stl[2], men[2]); else passed++;
    step();
    reset = 0; idle_in(); ALU_Result = 32'h77;
    @(negedge clock);
    total++; if (stl[2] !== 1'b0 || led[2] !== 16'h0) $display("FAIL rw_post got st=%b led=%h exp 0 0000", stl[2], led[2]); else passed++;
    total++; if (rw[2] !== 32'h77) $display("FAIL rw_idle got %h exp 00000077", rw[2]); else passed++;
    total++; if (g_dut[2].u_dut.rdata_q !== 32'h0) $display("FAIL rw_rdq got %h exp 0", g_dut[2].u_dut.rdata_q); else passed++;
    step();
  endtask

  task automatic test_rw_both();
    ALU_Result = 32'h20; Write_data = 32'hCAFE_0001; MemRead = 1; MemWrite = 1;
    @(negedge clock);
    total++; if (mwe[0] !== 1'b1 || stl[0] !== 1'b0 || maddr[0] !== 14'd8) $display("FAIL both_st got we=%b st=%b a=%0d exp 1 0 8", mwe[0], stl[0], maddr[0]); else passed++;
    step();
    idle_in();
    @(negedge clock);
    total++; if (stl !== 4'h0 || men !== 4'h0) $display("FAIL both_nowait got st=%b en=%b exp 0000 0000", stl, men); else passed++;
    total++; if (ram[8] !== 32'hCAFE_0001) $display("FAIL both_ram got %h exp cafe0001", ram[8]); else passed++;
    step();
  endtask

  initial begin
    test_reset();
    test_ram();
    test_latency();
    test_io();
    test_unmapped();
    test_reset_wait();
    test_rw_both();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
